// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters: output-register state
// encoding and the tkeep mask helper.
package stream_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  localparam int KEEP_MAX_W = 32;

  // Mask with lanes 0..lane set; callers cast the result down to their lane count.
  function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int unsigned lane);
    keep_mask = (32'd2 << lane) - 32'd1;
  endfunction

endpackage

// File: rtl/stream_pack_outreg.sv
// Output holding register for a packed stream word; keeps the word stable
// until the downstream handshake, and reloads in the same cycle when asked.
module stream_pack_outreg
  import stream_pkg::*;
#(
  parameter int Y_W   = 32,
  parameter int RATIO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Y_W-1:0]   load_data,
  input  logic [RATIO-1:0] load_keep,
  input  logic             load_last,
  input  logic             out_tready,
  output out_state_t       state,
  output logic [Y_W-1:0]   out_tdata,
  output logic [RATIO-1:0] out_tkeep,
  output logic             out_tlast,
  output logic             out_tvalid
);

  // The producer only loads when the register is empty or being drained,
  // so a load always wins and gives back-to-back words without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OUT_EMPTY;
      out_tdata <= '0;
      out_tkeep <= '0;
      out_tlast <= 1'b0;
    end else if (load) begin
      state     <= OUT_FULL;
      out_tdata <= load_data;
      out_tkeep <= load_keep;
      out_tlast <= load_last;
    end else if (out_tready) begin
      state <= OUT_EMPTY;
    end
  end

  assign out_tvalid = (state == OUT_FULL);

endmodule

// File: rtl/stream_matrix_pack.sv
// Packs RATIO narrow matrix elements into one wide word, framing words per
// matrix with a runtime depth and zero-padding the final partial word.
module stream_matrix_pack
  import stream_pkg::*;
#(
  parameter int X_W          = 8,
  parameter int RATIO        = 4,
  parameter int MATRIXSIZE_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [X_W-1:0]          in_tdata,
  input  logic                    in_tlast,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [X_W*RATIO-1:0]    out_tdata,
  output logic [RATIO-1:0]        out_tkeep,
  output logic                    out_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  input  logic [MATRIXSIZE_W-1:0] DEPTH,
  output logic                    len_err
);

  localparam int Y_W    = X_W * RATIO;
  localparam int LANE_W = $clog2(RATIO);

  logic [Y_W-1:0]          acc;
  logic [LANE_W-1:0]       lane;
  logic [MATRIXSIZE_W-1:0] elem_cnt;
  logic [MATRIXSIZE_W-1:0] depth_q;
  logic [MATRIXSIZE_W-1:0] eff_depth;
  logic                    is_last;
  logic                    closing_possible;
  logic                    in_hs;
  logic                    close;
  logic [Y_W-1:0]          word;
  logic [RATIO-1:0]        word_keep;
  out_state_t              out_state;

  // The first element of a matrix must already see the new depth, so the
  // live DEPTH input stands in for depth_q until it is captured.
  assign eff_depth        = (elem_cnt == '0) ? DEPTH : depth_q;
  assign is_last          = (elem_cnt == eff_depth - MATRIXSIZE_W'(1));
  assign closing_possible = (lane == LANE_W'(RATIO - 1)) || is_last;
  assign in_tready        = (out_state == OUT_EMPTY) || out_tready || !closing_possible;
  assign in_hs            = in_tvalid && in_tready;
  assign close            = in_hs && closing_possible;
  assign word_keep        = RATIO'(keep_mask(32'(lane)));

  always_comb begin
    word                     = acc;
    word[lane*X_W +: X_W]    = in_tdata;
  end

  // Lanes above the current one stay zero because the accumulator is
  // cleared on every close, which gives the padding for partial words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      lane <= '0;
    end else if (in_hs) begin
      if (close) begin
        acc  <= '0;
        lane <= '0;
      end else begin
        acc[lane*X_W +: X_W] <= in_tdata;
        lane                 <= lane + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      depth_q  <= '0;
      len_err  <= 1'b0;
    end else if (in_hs) begin
      if (elem_cnt == '0) begin
        depth_q <= DEPTH;
      end
      elem_cnt <= is_last ? '0 : elem_cnt + MATRIXSIZE_W'(1);
      if (in_tlast != is_last) begin
        len_err <= 1'b1;
      end
    end
  end

  stream_pack_outreg #(
    .Y_W   (Y_W),
    .RATIO (RATIO)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (close),
    .load_data  (word),
    .load_keep  (word_keep),
    .load_last  (is_last),
    .out_tready (out_tready),
    .state      (out_state),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid)
  );

endmodule

// File: tb/tb_stream_matrix_pack.sv
// Self-checking bench for stream_matrix_pack: directed scenarios plus a
// randomized phase, all scored against a queue-based packing model.
module tb_stream_matrix_pack;

  localparam int X_W   = 8;
  localparam int RATIO = 4;
  localparam int MSW   = 24;
  localparam int Y_W   = X_W * RATIO;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [X_W-1:0]   in_tdata = '0;
  logic             in_tlast = 1'b0;
  logic             in_tvalid = 1'b0;
  logic             in_tready;
  logic [Y_W-1:0]   out_tdata;
  logic [RATIO-1:0] out_tkeep;
  logic             out_tlast;
  logic             out_tvalid;
  logic             out_tready = 1'b1;
  logic [MSW-1:0]   DEPTH = 24'd8;
  logic             len_err;

  always #5 clk = ~clk;

  stream_matrix_pack #(
    .X_W          (X_W),
    .RATIO        (RATIO),
    .MATRIXSIZE_W (MSW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .DEPTH      (DEPTH),
    .len_err    (len_err)
  );

  typedef struct {
    logic [X_W-1:0] data;
    logic           last;
  } item_t;

  typedef struct {
    logic [Y_W-1:0]   data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  item_t          tx_q[$];
  word_t          exp_q[$];
  logic [X_W-1:0] pending[$];

  int    compared = 0;
  int    mismatched = 0;
  int    mdl_cnt = 0;
  int    mdl_depth = 0;
  bit    mdl_len_err = 1'b0;
  bit    close_pending = 1'b0;
  bit    hold_pending = 1'b0;
  word_t held;
  bit    in_hs_seen = 1'b0;
  int    accepted_cnt = 0;
  int    words_seen = 0;
  int    out_mode = 0;
  int    gap_pct = 0;
  bit    rand_depth = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: collect elements per matrix, emit a word every RATIO elements
  // or at the matrix end, low element in the low lane.
  function automatic void model_accept(input logic [X_W-1:0] d, input logic tl, input logic [MSW-1:0] depth_in);
    word_t w;
    bit    last;
    if (mdl_cnt == 0) mdl_depth = int'(depth_in);
    pending.push_back(d);
    last = (mdl_cnt + 1 == mdl_depth);
    if (tl != last) mdl_len_err = 1'b1;
    mdl_cnt = last ? 0 : mdl_cnt + 1;
    if (pending.size() == RATIO || last) begin
      w.data = '0;
      foreach (pending[i]) w.data = w.data | (Y_W'(pending[i]) << (X_W * i));
      w.keep = RATIO'((1 << pending.size()) - 1);
      w.last = last;
      exp_q.push_back(w);
      pending.delete();
      close_pending = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    mdl_cnt       = 0;
    mdl_depth     = 0;
    mdl_len_err   = 1'b0;
    close_pending = 1'b0;
    hold_pending  = 1'b0;
    in_hs_seen    = 1'b0;
    pending.delete();
    exp_q.delete();
    tx_q.delete();
  endfunction

  // Monitor: samples on the falling edge, between active edges.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_hs_seen = 1'b0;
        continue;
      end
      if (hold_pending) begin
        checkOutput("hold_valid", 64'(out_tvalid), 64'd1);
        checkOutput("hold_data", 64'(out_tdata), 64'(held.data));
        checkOutput("hold_keep", 64'(out_tkeep), 64'(held.keep));
        checkOutput("hold_last", 64'(out_tlast), 64'(held.last));
      end
      if (close_pending) begin
        checkOutput("latency_valid", 64'(out_tvalid), 64'd1);
        close_pending = 1'b0;
      end
      if (out_tvalid && out_tready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checkOutput("extra_word", 64'(out_tdata), 64'hDEAD_0000_0000);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          checkOutput("word_data", 64'(out_tdata), 64'(w.data));
          checkOutput("word_keep", 64'(out_tkeep), 64'(w.keep));
          checkOutput("word_last", 64'(out_tlast), 64'(w.last));
        end
      end
      hold_pending = out_tvalid && !out_tready;
      held.data    = out_tdata;
      held.keep    = out_tkeep;
      held.last    = out_tlast;
      if (out_tready) checkOutput("in_tready_when_out_ready", 64'(in_tready), 64'd1);
      in_hs_seen = in_tvalid && in_tready;
      if (in_hs_seen) begin
        accepted_cnt++;
        model_accept(in_tdata, in_tlast, DEPTH);
      end
    end
  end

  // Driver: updates inputs shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (in_hs_seen && tx_q.size() > 0) tx_q.delete(0);
      case (out_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
      if (rand_depth) DEPTH = MSW'($urandom_range(1, 9));
      if (!rst_n || tx_q.size() == 0 ||
          (!(in_tvalid && !in_hs_seen) && $urandom_range(0, 99) < gap_pct)) begin
        in_tvalid = 1'b0;
        in_tdata  = X_W'($urandom);
        in_tlast  = 1'($urandom_range(0, 1));
      end else begin
        in_tvalid = 1'b1;
        in_tdata  = tx_q[0].data;
        in_tlast  = tx_q[0].last;
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [X_W-1:0] base, input int tlast_idx, input bit rnd);
    item_t it;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        it.data = X_W'($urandom);
        it.last = ($urandom_range(0, 9) == 0);
      end else begin
        it.data = base + X_W'(i);
        it.last = (i == tlast_idx);
      end
      tx_q.push_back(it);
    end
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput({tag, "_drained"}, 64'(cyc < 5000), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    checkOutput("rst_out_tkeep", 64'(out_tkeep), 64'd0);
    checkOutput("rst_len_err", 64'(len_err), 64'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    int a0;
    int cyc;

    #12;
    checkOutput("reset_out_tvalid", 64'(out_tvalid), 64'd0);
    checkOutput("reset_out_tdata", 64'(out_tdata), 64'd0);
    checkOutput("reset_out_tkeep", 64'(out_tkeep), 64'd0);
    checkOutput("reset_out_tlast", 64'(out_tlast), 64'd0);
    checkOutput("reset_len_err", 64'(len_err), 64'd0);
    #10 rst_n = 1'b1;
    #1 checkOutput("reset_in_tready", 64'(in_tready), 64'd1);

    // Two full words from one 8-element matrix.
    @(posedge clk);
    DEPTH = 24'd8;
    w0 = words_seen;
    applyStimulus(8, 8'h01, 7, 1'b0);
    wait_idle("t1");
    checkOutput("t1_words", 64'(words_seen - w0), 64'd2);

    // Partial final word, then a second matrix starting in lane 0.
    DEPTH = 24'd6;
    w0 = words_seen;
    applyStimulus(6, 8'h11, 5, 1'b0);
    applyStimulus(6, 8'h21, 5, 1'b0);
    wait_idle("t2");
    checkOutput("t2_words", 64'(words_seen - w0), 64'd4);
    checkOutput("t2_len_err", 64'(len_err), 64'd0);

    // Output stalled for 10 cycles while 12 elements are offered.
    DEPTH = 24'd12;
    w0 = words_seen;
    a0 = accepted_cnt;
    out_mode = 2;
    applyStimulus(12, 8'h31, 11, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("t3_accepted_in_stall", 64'(accepted_cnt - a0), 64'd7);
    checkOutput("t3_in_tready_stalled", 64'(in_tready), 64'd0);
    out_mode = 0;
    wait_idle("t3");
    checkOutput("t3_words", 64'(words_seen - w0), 64'd3);

    // Early in_tlast: flagged, but framing follows DEPTH.
    DEPTH = 24'd4;
    w0 = words_seen;
    applyStimulus(4, 8'h41, 2, 1'b0);
    wait_idle("t4a");
    checkOutput("t4_len_err_set", 64'(len_err), 64'(mdl_len_err));
    applyStimulus(4, 8'h51, 3, 1'b0);
    wait_idle("t4b");
    checkOutput("t4_len_err_sticky", 64'(len_err), 64'd1);
    checkOutput("t4_words", 64'(words_seen - w0), 64'd2);

    // Reset after half a word discards it.
    applyStimulus(2, 8'h61, -1, 1'b0);
    cyc = 0;
    while (tx_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput("t5_prefill", 64'(cyc < 100), 64'd1);
    pulse_reset();
    w0 = words_seen;
    DEPTH = 24'd4;
    applyStimulus(4, 8'h71, 3, 1'b0);
    wait_idle("t5");
    checkOutput("t5_words", 64'(words_seen - w0), 64'd1);

    // DEPTH changed mid-matrix only affects the following matrix.
    DEPTH = 24'd8;
    w0 = words_seen;
    a0 = accepted_cnt;
    applyStimulus(8, 8'h81, 7, 1'b0);
    applyStimulus(4, 8'h91, 3, 1'b0);
    cyc = 0;
    while (accepted_cnt < a0 + 3 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    DEPTH = 24'd4;
    wait_idle("t6");
    checkOutput("t6_words", 64'(words_seen - w0), 64'd3);
    checkOutput("t6_len_err", 64'(len_err), 64'd0);

    // Randomized traffic, back-pressure and per-cycle DEPTH churn.
    pulse_reset();
    out_mode   = 1;
    gap_pct    = 25;
    rand_depth = 1'b1;
    applyStimulus(300, 8'h00, -1, 1'b1);
    wait_idle("rand");
    rand_depth = 1'b0;
    out_mode   = 0;
    gap_pct    = 0;
    checkOutput("rand_len_err", 64'(len_err), 64'(mdl_len_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
